bus_host_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-outstanding device port between NrHosts bus hosts, for example core data and debug SBA on a dedicated RAM or peripheral port.
- Grants combinationally in the request cycle.
- Records the owner of the outstanding access and routes the response back to that host only.
- A watchdog returns an error response if the device never answers.

---
 rtl/bus_host_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_host_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one single-outstanding device port between several bus hosts.
// Routes each response to the host that issued the access and synthesises an error on device silence.
module bus_host_arbiter #(
    parameter int NrHosts       = 2,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*4-1:0]              host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,
    output logic                              device_req_o,
    output logic [AddressWidth-1:0]           device_addr_o,
    output logic                              device_we_o,
    output logic [3:0]                        device_be_o,
    output logic [DataWidth-1:0]              device_wdata_o,
    input  logic                              device_rvalid_i,
    input  logic [DataWidth-1:0]              device_rdata_i,
    input  logic                              device_err_i,
    output logic                              stray_rsp_o
);

    localparam int PtrW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

    typedef enum logic {IDLE, WAIT_RSP} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]   owner_q, owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   winner;
    logic              accept, grant, rsp_hit, timeout_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        int idx;
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        winner         = '0;
        grant          = 1'b0;
        idx            = 0;
        host_gnt_o     = '0;
        host_rvalid_o  = '0;
        host_err_o     = '0;
        host_rdata_o   = '0;
        device_req_o   = 1'b0;
        device_addr_o  = '0;
        device_we_o    = 1'b0;
        device_be_o    = '0;
        device_wdata_o = '0;

        // A response cycle frees the port, so a new access may issue in that same cycle
        accept      = !rst_i && ((state_q == IDLE) || (state_q == WAIT_RSP && device_rvalid_i));
        rsp_hit     = !rst_i && (state_q == WAIT_RSP) && device_rvalid_i;
        timeout_hit = !rst_i && (TimeoutCycles != 0) && (state_q == WAIT_RSP)
                      && !device_rvalid_i && (cnt_q == CntLast);
        stray_rsp_o = !rst_i && (state_q == IDLE) && device_rvalid_i;

        if (accept) begin
            for (int i = 0; i < NrHosts; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= NrHosts) idx = idx - NrHosts;
                if (!grant && host_req_i[PtrW'(idx)]) begin
                    grant  = 1'b1;
                    winner = PtrW'(idx);
                end
            end
        end

        if (rsp_hit || timeout_hit) begin
            host_rvalid_o[owner_q] = 1'b1;
            host_err_o[owner_q]    = rsp_hit ? device_err_i : 1'b1;
            host_rdata_o           = rsp_hit ? device_rdata_i : '0;
            state_d                = IDLE;
        end

        if (state_q == WAIT_RSP && !device_rvalid_i && cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Owner is overwritten only after the old owner has been served above
        if (grant) begin
            host_gnt_o[winner] = 1'b1;
            device_req_o       = 1'b1;
            device_addr_o      = host_addr_i[int'(winner)*AddressWidth +: AddressWidth];
            device_we_o        = host_we_i[winner];
            device_be_o        = host_be_i[int'(winner)*4 +: 4];
            device_wdata_o     = host_wdata_i[int'(winner)*DataWidth +: DataWidth];
            rr_ptr_d           = (int'(winner) == NrHosts - 1) ? '0 : winner + 1'b1;
            owner_d            = winner;
            cnt_d              = '0;
            state_d            = WAIT_RSP;
        end
    end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Bench for bus_host_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a transaction-level reference model.
module tb_bus_host_arbiter;

    localparam int NH = 2;
    localparam int TC = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [1:0]    host_req;
    logic [1:0]    host_gnt;
    logic [63:0]   host_addr;
    logic [1:0]    host_we;
    logic [7:0]    host_be;
    logic [63:0]   host_wdata;
    logic [1:0]    host_rvalid;
    logic [31:0]   host_rdata;
    logic [1:0]    host_err;
    logic          dev_req;
    logic [31:0]   dev_addr;
    logic          dev_we;
    logic [3:0]    dev_be;
    logic [31:0]   dev_wdata;
    logic          dev_rvalid;
    logic [31:0]   dev_rdata;
    logic          dev_err;
    logic          stray;

    int n_checks = 0;
    int n_err    = 0;

    bus_host_arbiter #(
        .NrHosts(NH), .DataWidth(32), .AddressWidth(32), .TimeoutCycles(TC)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_req_i(host_req), .host_gnt_o(host_gnt),
        .host_addr_i(host_addr), .host_we_i(host_we), .host_be_i(host_be),
        .host_wdata_i(host_wdata), .host_rvalid_o(host_rvalid),
        .host_rdata_o(host_rdata), .host_err_o(host_err),
        .device_req_o(dev_req), .device_addr_o(dev_addr), .device_we_o(dev_we),
        .device_be_o(dev_be), .device_wdata_o(dev_wdata),
        .device_rvalid_i(dev_rvalid), .device_rdata_i(dev_rdata),
        .device_err_i(dev_err), .stray_rsp_o(stray)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  we;
        logic [7:0]  be;
        logic        rv;
        logic [31:0] rd;
        logic        er;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        logic [1:0]  e_err;
        logic [31:0] e_rd;
        logic        e_stray;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic [1:0] we,
                                input logic [7:0] be, input logic rv, input logic [31:0] rd,
                                input logic er, input logic [1:0] e_gnt, input logic [1:0] e_rv,
                                input logic [1:0] e_err, input logic [31:0] e_rd,
                                input logic e_stray);
        vec_t v;
        v.rst = rst; v.req = req; v.we = we; v.be = be; v.rv = rv; v.rd = rd; v.er = er;
        v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_err = e_err; v.e_rd = e_rd; v.e_stray = e_stray;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check settled combinational outputs, then advance past the edge
    task automatic run(input vec_t v, input string tag);
        int g;
        logic [31:0] e_addr, e_wd;
        logic        e_we;
        logic [3:0]  e_be;
        rst_i = v.rst; host_req = v.req; host_we = v.we; host_be = v.be;
        dev_rvalid = v.rv; dev_rdata = v.rd; dev_err = v.er;
        #2;
        g = (v.e_gnt == 2'b01) ? 0 : (v.e_gnt == 2'b10) ? 1 : -1;
        e_addr = (g >= 0) ? host_addr[g*32 +: 32]  : 32'h0;
        e_wd   = (g >= 0) ? host_wdata[g*32 +: 32] : 32'h0;
        e_we   = (g >= 0) ? v.we[g]                : 1'b0;
        e_be   = (g >= 0) ? v.be[g*4 +: 4]         : 4'h0;
        chk({tag, ".gnt"},     32'(host_gnt),    32'(v.e_gnt));
        chk({tag, ".dreq"},    32'(dev_req),     32'(g >= 0));
        chk({tag, ".daddr"},   dev_addr,         e_addr);
        chk({tag, ".dwe"},     32'(dev_we),      32'(e_we));
        chk({tag, ".dbe"},     32'(dev_be),      32'(e_be));
        chk({tag, ".dwdata"},  dev_wdata,        e_wd);
        chk({tag, ".rvalid"},  32'(host_rvalid), 32'(v.e_rv));
        chk({tag, ".err"},     32'(host_err),    32'(v.e_err));
        chk({tag, ".stray"},   32'(stray),       32'(v.e_stray));
        if (v.e_rv != 2'b00 || v.rst) chk({tag, ".rdata"}, host_rdata, v.e_rd);
        @(posedge clk_i);
        #1;
    endtask

    // Reference model state: what is outstanding, for whom, and who is next in line
    int m_pending, m_ptr, m_owner, m_wait;

    vec_t tbl[$];

    initial begin
        rst_i = 1'b1; host_req = '0; host_we = '0; host_be = 8'hFF;
        host_addr  = {32'h0020_0008, 32'h0010_0004};
        host_wdata = {32'h2222_0000, 32'h1111_0000};
        dev_rvalid = 1'b0; dev_rdata = '0; dev_err = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;

        // reset holds everything at zero and ignores requests
        tbl.push_back(mk(1, 2'b11, 0, 8'hFF, 1, 32'h1234_5678, 1, 2'b00, 2'b00, 2'b00, 32'h0, 0));
        // fairness: alternate grants, each response returns to the previous grantee
        tbl.push_back(mk(0, 2'b11, 0, 8'hFF, 0, 32'h0,         0, 2'b01, 2'b00, 2'b00, 32'h0, 0));
        tbl.push_back(mk(0, 2'b11, 0, 8'hFF, 1, 32'hA000_0001, 0, 2'b10, 2'b01, 2'b00, 32'hA000_0001, 0));
        tbl.push_back(mk(0, 2'b11, 0, 8'hFF, 1, 32'hA000_0002, 0, 2'b01, 2'b10, 2'b00, 32'hA000_0002, 0));
        tbl.push_back(mk(0, 2'b11, 0, 8'hFF, 1, 32'hA000_0003, 0, 2'b10, 2'b01, 2'b00, 32'hA000_0003, 0));
        tbl.push_back(mk(0, 2'b00, 0, 8'hFF, 1, 32'hA000_0004, 0, 2'b00, 2'b10, 2'b00, 32'hA000_0004, 0));
        // single host read
        tbl.push_back(mk(0, 2'b01, 0, 8'hFF, 0, 32'h0,         0, 2'b01, 2'b00, 2'b00, 32'h0, 0));
        tbl.push_back(mk(0, 2'b00, 0, 8'hFF, 1, 32'hCAFE_F00D, 0, 2'b00, 2'b01, 2'b00, 32'hCAFE_F00D, 0));
        // contention after host1 was last granted
        tbl.push_back(mk(0, 2'b10, 0, 8'hFF, 0, 32'h0,         0, 2'b10, 2'b00, 2'b00, 32'h0, 0));
        tbl.push_back(mk(0, 2'b00, 0, 8'hFF, 1, 32'hB000_0001, 0, 2'b00, 2'b10, 2'b00, 32'hB000_0001, 0));
        tbl.push_back(mk(0, 2'b11, 0, 8'hFF, 0, 32'h0,         0, 2'b01, 2'b00, 2'b00, 32'h0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 8'hFF, 0, 32'h0,         0, 2'b00, 2'b00, 2'b00, 32'h0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 8'hFF, 1, 32'hB000_0002, 0, 2'b10, 2'b01, 2'b00, 32'hB000_0002, 0));
        tbl.push_back(mk(0, 2'b00, 0, 8'hFF, 1, 32'hB000_0003, 0, 2'b00, 2'b10, 2'b00, 32'hB000_0003, 0));
        // device error on a partial write
        tbl.push_back(mk(0, 2'b01, 2'b01, 8'hF3, 0, 32'h0,     0, 2'b01, 2'b00, 2'b00, 32'h0, 0));
        tbl.push_back(mk(0, 2'b00, 0, 8'hFF, 1, 32'h0,         1, 2'b00, 2'b01, 2'b01, 32'h0, 0));
        // response with nothing outstanding
        tbl.push_back(mk(0, 2'b00, 0, 8'hFF, 1, 32'hDEAD_BEEF, 1, 2'b00, 2'b00, 2'b00, 32'h0, 1));

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // timeout: host1 granted, device silent; host0 waits and is never dropped
        run(mk(0, 2'b10, 0, 8'hFF, 0, 32'h0, 0, 2'b10, 2'b00, 2'b00, 32'h0, 0), "to_gnt");
        for (int i = 0; i < TC - 1; i++)
            run(mk(0, 2'b01, 0, 8'hFF, 0, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0), "to_wait");
        run(mk(0, 2'b01, 0, 8'hFF, 0, 32'h0, 0, 2'b00, 2'b10, 2'b10, 32'h0, 0), "to_fire");
        run(mk(0, 2'b01, 0, 8'hFF, 1, 32'h5555_5555, 0, 2'b01, 2'b00, 2'b00, 32'h0, 1), "to_late");
        run(mk(0, 2'b00, 0, 8'hFF, 1, 32'hC000_0001, 0, 2'b00, 2'b01, 2'b00, 32'hC000_0001, 0), "to_next");

        // response in the timeout cycle is a normal response
        run(mk(0, 2'b10, 0, 8'hFF, 0, 32'h0, 0, 2'b10, 2'b00, 2'b00, 32'h0, 0), "pre_gnt");
        for (int i = 0; i < TC - 1; i++)
            run(mk(0, 2'b00, 0, 8'hFF, 0, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0), "pre_wait");
        run(mk(0, 2'b00, 0, 8'hFF, 1, 32'hD000_0001, 0, 2'b00, 2'b10, 2'b00, 32'hD000_0001, 0), "pre_rsp");

        // reset mid-transaction drops the access and rewinds the pointer
        run(mk(0, 2'b01, 0, 8'hFF, 0, 32'h0, 0, 2'b01, 2'b00, 2'b00, 32'h0, 0), "rst_gnt");
        run(mk(1, 2'b11, 0, 8'hFF, 1, 32'hE000_0000, 1, 2'b00, 2'b00, 2'b00, 32'h0, 0), "rst_on");
        run(mk(0, 2'b11, 0, 8'hFF, 1, 32'hE000_0001, 0, 2'b01, 2'b00, 2'b00, 32'h0, 1), "rst_after");
        run(mk(0, 2'b10, 0, 8'hFF, 1, 32'hE000_0002, 0, 2'b10, 2'b01, 2'b00, 32'hE000_0002, 0), "rst_rsp0");
        run(mk(0, 2'b00, 0, 8'hFF, 1, 32'hE000_0003, 0, 2'b00, 2'b10, 2'b00, 32'hE000_0003, 0), "rst_rsp1");

        // randomized traffic against the reference model
        host_req = '0;
        m_pending = 0; m_ptr = 0; m_owner = 0; m_wait = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic        r_rst, rv, er, rsp, to;
            logic [31:0] rd;
            int          win;
            vec_t        v;
            r_rst = (cyc == 0) || ($urandom_range(0, 49) == 0);
            for (int h = 0; h < NH; h++) begin
                if (!host_req[h] && $urandom_range(0, 9) < 4) begin
                    host_req[h]          = 1'b1;
                    host_addr[h*32 +: 32]  = $urandom;
                    host_wdata[h*32 +: 32] = $urandom;
                    host_we[h]           = 1'($urandom_range(0, 1));
                    host_be[h*4 +: 4]    = 4'($urandom);
                end
            end
            rv = (m_pending != 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
            rd = $urandom;
            er = ($urandom_range(0, 3) == 0);

            win = -1;
            rsp = 1'b0; to = 1'b0;
            v = mk(r_rst, host_req, host_we, host_be, rv, rd, er, 2'b00, 2'b00, 2'b00, 32'h0, 0);
            if (!r_rst) begin
                rsp = (m_pending != 0) && rv;
                to  = (m_pending != 0) && !rv && (m_wait == TC - 1);
                v.e_stray = (m_pending == 0) && rv;
                if (m_pending == 0 || rv) begin
                    for (int k = 0; k < NH; k++) begin
                        int h;
                        h = (m_ptr + k) % NH;
                        if (win < 0 && host_req[h]) win = h;
                    end
                end
                if (win >= 0) v.e_gnt = 2'(1 << win);
                if (rsp || to) v.e_rv = 2'(1 << m_owner);
                if (rsp && er) v.e_err = 2'(1 << m_owner);
                if (to)        v.e_err = 2'(1 << m_owner);
                if (rsp)       v.e_rd  = rd;
            end
            run(v, "rand");

            if (r_rst) begin
                m_pending = 0; m_ptr = 0; m_owner = 0; m_wait = 0;
            end else if (win >= 0) begin
                m_pending = 1; m_owner = win; m_ptr = (win + 1) % NH; m_wait = 0;
                host_req[win] = 1'b0;
            end else if (rsp || to) begin
                m_pending = 0;
            end else if (m_pending != 0) begin
                m_wait++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
